// File: rtl/mips_pkg.sv
// Shared geometry and controller state encoding for the direct-mapped cache.
package mips_pkg;

  localparam int unsigned TAG_W = 22;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned OFF_W = 3;
  localparam int unsigned LINES = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StFill,
    StWriteMem
  } state_e;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, datapath and memory signals of the cache controller.
// The slave modport is the controller's view.
interface cache_ctrl_if
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic             cpu_ready;
  logic             inv;
  logic [IDX_W-1:0] cache_idx;
  logic [OFF_W-1:0] cache_idb;
  logic             cache_we;
  logic             cache_fill;
  logic [IDX_W-1:0] cache_idx_mem;
  logic             mem_rd;
  logic             mem_wr;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, inv, mem_ack,
    output cpu_ready, cache_idx, cache_idb, cache_we, cache_fill, cache_idx_mem,
    output mem_rd, mem_wr, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, inv, mem_ack,
    input  cpu_ready, cache_idx, cache_idb, cache_we, cache_fill, cache_idx_mem,
    input  mem_rd, mem_wr, mem_addr, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/cache_tag_store.sv
// Tag and valid arrays: one combinational lookup port, one write port, clear-all.
// Only the valid bits are reset; tags are don't-care while their line is invalid.
module cache_tag_store
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] lkp_idx_i,
  output logic             lkp_valid_o,
  output logic [TAG_W-1:0] lkp_tag_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign lkp_valid_o = valid_q[lkp_idx_i];
  assign lkp_tag_o   = tag_q[lkp_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating hit/miss statistics.
module cache_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic             refill_q, refill_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             lkp_valid;
  logic [TAG_W-1:0] lkp_tag;
  logic             hit, clr, tag_wr, hit_inc, miss_inc;
  logic             cpu_ready, cache_we, cache_fill, mem_rd, mem_wr;
  logic [31:0]      mem_addr;

  wire [TAG_W-1:0] tag = addr_q[31:10];
  wire [IDX_W-1:0] idx = addr_q[9:5];
  wire [OFF_W-1:0] idb = addr_q[4:2];

  cache_tag_store u_tag_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .lkp_idx_i  (idx),
    .lkp_valid_o(lkp_valid),
    .lkp_tag_o  (lkp_tag),
    .wr_en_i    (tag_wr),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag)
  );

  assign hit = lkp_valid && (lkp_tag == tag);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    refill_d   = refill_q;
    cpu_ready  = 1'b0;
    cache_we   = 1'b0;
    cache_fill = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    clr        = 1'b0;
    tag_wr     = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.inv) begin
          clr = 1'b1;
        end else if (bus.cpu_req) begin
          addr_d   = bus.cpu_addr;
          we_d     = bus.cpu_we;
          refill_d = 1'b0;
          state_d  = StCompare;
        end
      end
      StCompare: begin
        // The compare that follows a fill was already counted as a miss.
        hit_inc  = hit && !refill_q;
        miss_inc = !hit && !refill_q;
        if (we_q) begin
          cache_we = hit;
          state_d  = StWriteMem;
        end else if (hit) begin
          cpu_ready = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StFill;
        end
      end
      StFill: begin
        mem_rd   = 1'b1;
        mem_addr = {addr_q[31:5], 5'b0};
        if (bus.mem_ack) begin
          cache_fill = 1'b1;
          tag_wr     = 1'b1;
          refill_d   = 1'b1;
          state_d    = StCompare;
        end
      end
      StWriteMem: begin
        mem_wr   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (bus.mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    hit_cnt_d  = (hit_inc && !(&hit_cnt_q)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss_inc && !(&miss_cnt_q)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.cpu_ready     = cpu_ready;
  assign bus.cache_idx     = (state_q != StIdle) ? idx : '0;
  assign bus.cache_idb     = (state_q != StIdle) ? idb : '0;
  assign bus.cache_we      = cache_we;
  assign bus.cache_fill    = cache_fill;
  assign bus.cache_idx_mem = cache_fill ? idx : '0;
  assign bus.mem_rd        = mem_rd;
  assign bus.mem_wr        = mem_wr;
  assign bus.mem_addr      = mem_addr;
  assign bus.hit_cnt       = hit_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl; a second 3-bit-counter instance shares the
// stimulus so counter saturation is reached in a few accesses.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  cache_ctrl_if #(.CNT_W(16)) bus ();
  cache_ctrl_if #(.CNT_W(3))  bus_s ();

  cache_ctrl #(.CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  cache_ctrl #(.CNT_W(3)) dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s.slave)
  );

  assign bus_s.cpu_req  = bus.cpu_req;
  assign bus_s.cpu_we   = bus.cpu_we;
  assign bus_s.cpu_addr = bus.cpu_addr;
  assign bus_s.inv      = bus.inv;
  assign bus_s.mem_ack  = bus.mem_ack;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, ":hit_cnt"}, 32'(bus.hit_cnt), 32'(exp_hits));
    check({tag, ":miss_cnt"}, 32'(bus.miss_cnt), 32'(exp_miss));
    check({tag, ":hit_cnt_sat"}, 32'(bus_s.hit_cnt), 32'(sat7(exp_hits)));
    check({tag, ":miss_cnt_sat"}, 32'(bus_s.miss_cnt), 32'(sat7(exp_miss)));
  endtask

  // Starts at a negedge in IDLE and returns at a negedge in IDLE.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input bit exp_hit, input int ack_dly);
    logic [31:0] a;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    @(negedge clk);
    check({tag, ":idx"}, 32'(bus.cache_idx), 32'(addr[9:5]));
    check({tag, ":idb"}, 32'(bus.cache_idb), 32'(addr[4:2]));
    check({tag, ":cache_we"}, 32'(bus.cache_we), 32'(we & exp_hit));
    check({tag, ":cmp_mem"}, {30'b0, bus.mem_rd, bus.mem_wr}, 32'h0);
    if (!we && exp_hit) begin
      check({tag, ":hit_ready"}, 32'(bus.cpu_ready), 32'h1);
      exp_hits++;
      @(negedge clk);
    end else begin
      check({tag, ":cmp_ready"}, 32'(bus.cpu_ready), 32'h0);
      if (exp_hit) exp_hits++;
      else exp_miss++;
      a = we ? {addr[31:2], 2'b00} : {addr[31:5], 5'b0};
      @(negedge clk);
      for (int i = 0; i < ack_dly; i++) begin
        check({tag, ":mem_rd"}, 32'(bus.mem_rd), 32'(!we));
        check({tag, ":mem_wr"}, 32'(bus.mem_wr), 32'(we));
        check({tag, ":mem_addr"}, bus.mem_addr, a);
        check({tag, ":wait_ready_fill"}, {30'b0, bus.cpu_ready, bus.cache_fill}, 32'h0);
        @(negedge clk);
      end
      bus.mem_ack = 1'b1;
      #1;
      if (we) begin
        check({tag, ":ack_ready"}, 32'(bus.cpu_ready), 32'h1);
        check({tag, ":ack_mem_wr"}, 32'(bus.mem_wr), 32'h1);
      end else begin
        check({tag, ":fill"}, 32'(bus.cache_fill), 32'h1);
        check({tag, ":idx_mem"}, 32'(bus.cache_idx_mem), 32'(addr[9:5]));
        check({tag, ":fill_ready"}, 32'(bus.cpu_ready), 32'h0);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!we) begin
        #1;
        check({tag, ":refill_ready"}, 32'(bus.cpu_ready), 32'h1);
        check({tag, ":refill_mem_rd"}, 32'(bus.mem_rd), 32'h0);
        @(negedge clk);
      end
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    check({tag, ":idle_out"}, {29'b0, bus.cpu_ready, bus.mem_rd, bus.mem_wr}, 32'h0);
    check_cnt(tag);
  endtask

  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.inv      = 1'b0;
    bus.mem_ack  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst:ready", 32'(bus.cpu_ready), 32'h0);
    check("rst:mem", {30'b0, bus.mem_rd, bus.mem_wr}, 32'h0);
    check("rst:mem_addr", bus.mem_addr, 32'h0);
    check("rst:cache", {bus.cache_idx, bus.cache_idb, bus.cache_we, bus.cache_fill}, 32'h0);
    check_cnt("rst");
    rst_n = 1'b1;
    @(negedge clk);

    access("ld420", 1'b0, 32'h0000_0420, 1'b0, 3);
    access("ld424", 1'b0, 32'h0000_0424, 1'b1, 0);
    access("st428", 1'b1, 32'h0000_0428, 1'b1, 2);
    access("st8000", 1'b1, 32'h0000_8000, 1'b0, 1);
    access("ld420b", 1'b0, 32'h0000_0420, 1'b1, 0);
    access("ld820", 1'b0, 32'h0000_0820, 1'b0, 2);
    access("ld820b", 1'b0, 32'h0000_0820, 1'b1, 0);
    access("ld420c", 1'b0, 32'h0000_0420, 1'b0, 1);

    // Request presented together with inv must wait one cycle.
    bus.inv      = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0820;
    @(negedge clk);
    check("inv:mem_rd", 32'(bus.mem_rd), 32'h0);
    bus.inv = 1'b0;
    access("inv_ld820", 1'b0, 32'h0000_0820, 1'b0, 1);

    for (int i = 0; i < 5; i++) begin
      access("sat_ld", 1'b0, 32'h0000_082c, 1'b1, 0);
    end

    // Reset in the middle of a fill abandons the request.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0420;
    @(negedge clk);
    check("rstfill:cmp_ready", 32'(bus.cpu_ready), 32'h0);
    @(negedge clk);
    check("rstfill:mem_rd_on", 32'(bus.mem_rd), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstfill:mem_rd_off", 32'(bus.mem_rd), 32'h0);
    check("rstfill:mem_addr", bus.mem_addr, 32'h0);
    exp_hits = 0;
    exp_miss = 0;
    check_cnt("rstfill");
    bus.cpu_req = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstfill:ack_ignored", {29'b0, bus.cache_fill, bus.mem_rd, bus.cpu_ready}, 32'h0);
    bus.mem_ack = 1'b0;
    access("rstfill_ld420", 1'b0, 32'h0000_0420, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of hit/miss statistics counters.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cpu_req  input  1  CPU access request, held until cpu_ready.
REQ-005 SHALL have port: cpu_we  input  1  1 = store, 0 = load; held with cpu_req.
REQ-006 SHALL have port: cpu_addr  input  32  byte address: tag [31:10], index [9:5], word [4:2], [1:0] ignored.
REQ-007 SHALL have port: cpu_ready  output  1  one-cycle access-complete pulse.
REQ-008 SHALL have port: inv  input  1  invalidate-all pulse.
REQ-009 SHALL have port: cache_idx / cache_idb  output  5 / 3  datapath line and word select.
REQ-010 SHALL have port: cache_we  output  1  datapath word write strobe.
REQ-011 SHALL have port: cache_fill  output  1  datapath line fill strobe; cache_idx_mem  output  5  line to fill.
REQ-012 SHALL have port: mem_rd  output  1  line read request; mem_wr  output  1  word write request.
REQ-013 SHALL have port: mem_addr  output  32  read: {tag,index,5'b0}; write: {cpu_addr[31:2],2'b00}.
REQ-014 SHALL have port: mem_ack  input  1  memory completion; line data valid on datapath data_mem in the ack cycle.
REQ-015 SHALL have port: hit_cnt / miss_cnt  output  CNT_W  saturating statistics.

Function
REQ-016 SHALL be direct-mapped, 32 lines, write-through, no write-allocate; controller owns tag and valid arrays.
REQ-017 SHALL implement states IDLE, COMPARE, FILL, WRITE_MEM.
REQ-018 IDLE: cpu_req=1 and inv=0 -> register cpu_addr/cpu_we, go COMPARE; inv=1 -> clear all valid bits, stay IDLE, ignore cpu_req that cycle.
REQ-019 COMPARE: hit = valid[index] and tag[index]==latched tag; cache_idx/cache_idb driven from the latched address in all states except IDLE.
REQ-020 Load hit: cpu_ready=1 in COMPARE, return IDLE; latency = 2 cycles from accepted cpu_req.
REQ-021 Load miss: go FILL; FILL holds mem_rd=1 and mem_addr constant until mem_ack.
REQ-022 FILL with mem_ack=1: cache_fill=1, cache_idx_mem=index, tag written, valid set, return COMPARE (then hits).
REQ-023 Store: in COMPARE, cache_we=1 on hit only; always go WRITE_MEM.
REQ-024 WRITE_MEM holds mem_wr=1 until mem_ack; ack cycle: cpu_ready=1, return IDLE.
REQ-025 mem_rd and mem_wr SHALL never be asserted together; both 0 outside FILL/WRITE_MEM.
REQ-026 hit_cnt increments on first COMPARE of a hit access, miss_cnt on load miss or store miss; the post-fill COMPARE SHALL NOT count; both saturate at all-ones.
REQ-027 inv outside IDLE SHALL be ignored.
REQ-028 mem_ack outside FILL/WRITE_MEM SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, all valid bits 0, counters 0, and all outputs 0, including mid-FILL/WRITE_MEM (request abandoned, no fill).
REQ-030 Tag array contents need not be reset.

Structure
REQ-031 Shared package mips_pkg SHALL hold TAG_W=22, IDX_W=5, OFF_W=3, LINES=32 and the state enum.
REQ-032 Tag/valid storage SHALL be sub-module cache_tag_store (lookup port, write port, clear-all).

Verification
REQ-033 Reset, load 0x0000_0420 -> miss, mem_rd with mem_addr 0x0000_0420, ack after 3 cycles -> cache_fill idx_mem 1, cpu_ready 2 cycles later; miss_cnt=1.
REQ-034 Load 0x0000_0424 after REQ-033 -> cpu_ready 2 cycles after req, no mem_rd, hit_cnt=1.
REQ-035 Store 0x0000_0428 (hit) -> cache_we=1 idx 1 idb 2, mem_wr addr 0x0000_0428 until ack, then cpu_ready; store 0x0000_8000 (miss) -> cache_we=0, mem_wr only.
REQ-036 Load 0x0000_0420 then 0x0000_0820 (same index 1, new tag) -> second misses, refills, tag replaced; inv then 0x0000_0820 -> miss again.
REQ-037 rst_n=0 during FILL -> mem_rd drops immediately, later ack ignored, line 1 invalid.
REQ-038 Force hit_cnt to 16'hFFFF, one more hit -> stays 16'hFFFF.
